tlul_main_mem_adapter: RTL

- TL-UL device-side endpoint on the DMA CTN port (main-memory path).
- Accepts the DMA's `tlul_pkg::tl_h2d_t` requests and drives a simple in-order req/gnt/rvalid memory interface toward the main-memory controller.
- Returns `tlul_pkg::tl_d2h_t` responses strictly in order, with bounded outstanding transactions and local error responses.

---
 rtl/tlul_main_mem_adapter_pkg.sv | 23 ++
 rtl/tlul_pkg.sv | 47 ++++
 rtl/prim_fifo_sync.sv | 44 ++++
 rtl/tlul_rsp_intg_gen.sv | 23 ++
 rtl/tlul_main_mem_adapter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/tlul_main_mem_adapter_pkg.sv
// Types shared by the main-memory adapter: the per-transaction tracker entry
// pushed on every accepted A request, the response entry captured on every
// memory rvalid, and the width helper for the outstanding counter.
package tlul_main_mem_adapter_pkg;

  typedef struct packed {
    logic [7:0] source;
    logic [1:0] size;
    logic [2:0] opcode;
    logic       err;
  } trk_entry_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_entry_t;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: the A/D channel structs and opcode encodings
// used by the main-memory adapter. Field widths match a 32-bit TL-UL bus
// with 8-bit source IDs.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO, Depth must be a power of two.
// Ports: wvalid_i/wdata_i push, rvalid_o/rdata_o show the head,
// rready_i pops. Pushes when full and pops when empty are ignored.
module prim_fifo_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             push, pop;

  assign push     = wvalid_i && (cnt_q != (PtrW+1)'(Depth));
  assign pop      = rready_i && (cnt_q != '0);
  assign rvalid_o = (cnt_q != '0);
  assign rdata_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PtrW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PtrW+1)'(1);
    end
  end
endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Fills d_user integrity fields on a D-channel response; all other fields
// pass straight through. Uses a lightweight 7-bit XOR fold over the
// response header and over the data word.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);
  function automatic logic [6:0] fold7(input logic [34:0] v);
    return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28];
  endfunction

  // Incoming d_user is always replaced.
  logic unused_user;
  assign unused_user = ^tl_i.d_user;

  always_comb begin
    tl_o = tl_i;
    tl_o.d_user.rsp_intg  = fold7({29'b0, tl_i.d_opcode, tl_i.d_size, tl_i.d_error});
    tl_o.d_user.data_intg = fold7({3'b0, tl_i.d_data});
  end
endmodule

// File: rtl/tlul_main_mem_adapter.sv
// TL-UL device endpoint on the DMA main-memory path.
// Ports: clk_i/rst_ni (async active-low); tl_i/tl_o TL-UL A and D channels;
// mem_req_o/mem_gnt_i request handshake with mem_we_o, mem_addr_o (byte
// offset from BaseAddr), mem_be_o, mem_wdata_o; mem_rvalid_i/mem_rdata_i/
// mem_err_i in-order responses, one per grant.
// Illegal requests never reach memory; they are answered locally with
// d_error=1, in order behind any earlier memory transactions.
module tlul_main_mem_adapter
  import tlul_pkg::*;
  import tlul_main_mem_adapter_pkg::*;
#(
  parameter int unsigned Outstanding  = 4,
  parameter logic [31:0] BaseAddr     = 32'h8000_0000,
  parameter logic [31:0] MemSize      = 32'h1000_0000,
  parameter int unsigned MemAddrWidth = 28
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  tl_h2d_t                 tl_i,
  output tl_d2h_t                 tl_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [3:0]              mem_be_o,
  output logic [31:0]             mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [31:0]             mem_rdata_i,
  input  logic                    mem_err_i
);
  localparam int unsigned CntW = cnt_width(Outstanding);

  logic [CntW-1:0]         inflight_q, inflight_d, mem_pend_q, mem_pend_d;
  logic                    req_q, req_d, we_q, we_d;
  logic [MemAddrWidth-1:0] addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  tl_d2h_t                 d_q, d_d, d_raw;

  logic [31:0] a_offset;
  logic        a_in_range, a_op_ok, a_size_ok, a_mask_ok, a_aligned, a_err;
  logic        a_ready, a_hs, d_hs, mem_issue;
  trk_entry_t  trk_wdata, trk_head;
  rsp_entry_t  rsp_wdata, rsp_head;
  logic        trk_valid, rsp_valid, d_load;

  logic unused_param;
  assign unused_param = ^tl_i.a_param;

  // Request decode
  always_comb begin
    a_offset   = tl_i.a_address - BaseAddr;
    a_in_range = (tl_i.a_address >= BaseAddr) && (a_offset < MemSize);
    a_op_ok    = (tl_i.a_opcode == Get) || (tl_i.a_opcode == PutFullData) ||
                 (tl_i.a_opcode == PutPartialData);
    a_size_ok  = (tl_i.a_size != 2'd3);
    a_mask_ok  = !((tl_i.a_opcode == PutFullData) && (tl_i.a_size == 2'd2) &&
                   (tl_i.a_mask != 4'hF));
    case (tl_i.a_size)
      2'd1:    a_aligned = !tl_i.a_address[0];
      2'd2:    a_aligned = (tl_i.a_address[1:0] == 2'b00);
      default: a_aligned = 1'b1;
    endcase
    a_err = !(a_in_range && a_op_ok && a_size_ok && a_mask_ok && a_aligned);
  end

  // A new request may only be taken if the request register is free this
  // cycle, i.e. it is idle or being granted right now.
  assign a_ready   = (inflight_q < CntW'(Outstanding)) && !(req_q && !mem_gnt_i);
  assign a_hs      = tl_i.a_valid && a_ready;
  assign d_hs      = d_q.d_valid && tl_i.d_ready;
  assign mem_issue = req_q && mem_gnt_i;

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (a_hs && !a_err) begin
      req_d   = 1'b1;
      we_d    = (tl_i.a_opcode != Get);
      addr_d  = {a_offset[MemAddrWidth-1:2], 2'b00};
      be_d    = tl_i.a_mask;
      wdata_d = tl_i.a_data;
    end else if (mem_issue) begin
      req_d = 1'b0;
    end
  end

  assign trk_wdata = '{source: tl_i.a_source, size: tl_i.a_size,
                       opcode: tl_i.a_opcode, err: a_err};
  assign rsp_wdata = '{rdata: mem_rdata_i, err: mem_err_i};

  prim_fifo_sync #(.Width($bits(trk_entry_t)), .Depth(Outstanding)) u_trk_fifo (
    .clk_i, .rst_ni,
    .wvalid_i (a_hs),
    .wdata_i  (trk_wdata),
    .rvalid_o (trk_valid),
    .rready_i (d_load),
    .rdata_o  (trk_head)
  );

  prim_fifo_sync #(.Width($bits(rsp_entry_t)), .Depth(Outstanding)) u_rsp_fifo (
    .clk_i, .rst_ni,
    .wvalid_i (mem_rvalid_i),
    .wdata_i  (rsp_wdata),
    .rvalid_o (rsp_valid),
    .rready_i (d_load && !trk_head.err),
    .rdata_o  (rsp_head)
  );

  // The D register is a one-entry output stage: the FIFO heads are consumed
  // when it loads, so it can refill in the same cycle as a D handshake.
  assign d_load = trk_valid && (trk_head.err || rsp_valid) && (!d_q.d_valid || d_hs);

  always_comb begin
    d_d = d_q;
    if (d_load) begin
      d_d.d_valid  = 1'b1;
      d_d.d_opcode = (trk_head.opcode == Get) ? AccessAckData : AccessAck;
      d_d.d_param  = '0;
      d_d.d_size   = trk_head.size;
      d_d.d_source = trk_head.source;
      d_d.d_sink   = '0;
      // Error entries have no memory data; their rsp_head is not theirs.
      d_d.d_data   = ((trk_head.opcode == Get) && !trk_head.err) ? rsp_head.rdata : '0;
      d_d.d_error  = trk_head.err || rsp_head.err;
    end else if (d_hs) begin
      d_d.d_valid = 1'b0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (a_hs && !d_hs)      inflight_d = inflight_q + CntW'(1);
    else if (d_hs && !a_hs) inflight_d = inflight_q - CntW'(1);
    mem_pend_d = mem_pend_q;
    if (mem_issue && !mem_rvalid_i)      mem_pend_d = mem_pend_q + CntW'(1);
    else if (mem_rvalid_i && !mem_issue) mem_pend_d = mem_pend_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      mem_pend_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      d_q        <= '0;
    end else begin
      inflight_q <= inflight_d;
      mem_pend_q <= mem_pend_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      d_q        <= d_d;
    end
  end

  always_comb begin
    d_raw         = d_q;
    d_raw.a_ready = a_ready;
    d_raw.d_user  = '0;
  end

  tlul_rsp_intg_gen u_intg (
    .tl_i (d_raw),
    .tl_o (tl_o)
  );

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  rvalid_without_req_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (mem_pend_q != '0));

endmodule
